stopwatch_timer: RTL
====================

Name: stopwatch_timer

Overview:
- Next-generation time base for the StopWatch display path: one block provides both an up-counting stopwatch and a down-counting countdown timer.
- Adds start/pause control, lap-hold capture, preset load, and an expiry flag.
- The divider and minutes range are parametrised.
- Pulse inputs are single-cycle and come from the existing debounce/edge-detect logic. Outputs feed the seven-segment encoder.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 100, count resolution (100 = centiseconds); DIV = CLK_HZ/TICK_HZ, must be integer >= 2.
- MIN_MAX, 59, maximum minutes value (up to 99).
- MW, $clog2(MIN_MAX+1), minutes width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- start_stop  in  1  one-cycle pulse; toggles run/pause.
- lap  in  1  one-cycle pulse; lap capture/release, or clear when paused.
- mode_down  in  1  0 = stopwatch (up), 1 = timer (down); sampled only when not running.
- load  in  1  one-cycle pulse; copies preset into counters.
- preset_cs  in  7  preset centiseconds.
- preset_secs  in  6  preset seconds.
- preset_mins  in  MW  preset minutes.
- cs, secs, mins  out  7/6/MW  live counter values.
- disp_cs, disp_secs, disp_mins  out  7/6/MW  live values, or lap values while lap_hold=1.
- running  out  1  high in RUN.
- lap_hold  out  1  display frozen on lap value.
- done  out  1  one-cycle pulse when the timer reaches zero.
- expired  out  1  level; high in DONE.
- wrap  out  1  one-cycle pulse when the up count rolls over from MIN_MAX:59:99 to 0.

Behaviour:
- Reset:
  - state IDLE; all counters, lap registers and divider = 0.
  - running, lap_hold, done, expired and wrap = 0; latched mode = up.
- States:
  - IDLE (zero/loaded, not started), RUN, PAUSE, DONE.
- Divider:
  - Counts 0..DIV-1 only in RUN; tick when divider==DIV-1, then wraps to 0.
  - Cleared on every entry to RUN from IDLE/DONE, and on load.
  - Held, not cleared, across PAUSE.
- Up mode, per tick:
  - cs increments; 99 -> 0 carries to secs.
  - secs 59 -> 0 carries to mins.
  - mins MIN_MAX -> 0 pulses wrap in the same cycle the counters show 0. Counting continues.
- Down mode, per tick:
  - cs decrements; 0 -> 99 borrows from secs.
  - secs 0 -> 59 borrows from mins.
  - When the next value is 00:00:00, counters load 0, done pulses, state goes to DONE and the divider stops.
- Transitions:
  - IDLE/PAUSE + start_stop -> RUN. Exception: down mode with counters all zero ignores start_stop.
  - mode_down is latched on IDLE -> RUN only; PAUSE -> RUN keeps the latched mode.
  - RUN + start_stop -> PAUSE.
  - DONE + start_stop or load -> IDLE; load also copies preset.
  - In DONE, lap has no effect.
- Tick and start_stop in the same cycle: the tick is applied, then the state changes.
- Lap:
  - In RUN with lap_hold=0: capture the live values (pre-tick) into lap registers and set lap_hold.
  - In RUN with lap_hold=1: clear lap_hold.
  - In PAUSE: clear counters, lap registers, divider and lap_hold; go to IDLE.
  - In IDLE: clear lap_hold only.
- start_stop and lap in the same cycle: start_stop wins and lap is ignored.
- load:
  - Honoured in IDLE, PAUSE and DONE; ignored in RUN.
  - Preset clipping: cs > 99 -> 99, secs > 59 -> 59, mins > MIN_MAX -> MIN_MAX.
  - load clears lap_hold.
  - Load in PAUSE stays in PAUSE.
- Reset mid-RUN returns to the reset state on the next edge, overriding all inputs.
- done and wrap are never high outside the single cycle after the qualifying tick edge.

Decomposition:
- Package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - Constants CS_MAX=99, SEC_MAX=59, CS_W=7, SEC_W=6.
- Sub-module wrap_updown_counter #(MAX, WIDTH):
  - Inputs: en, down, load, load_val.
  - Outputs: cnt, and a carry/borrow out that is combinational when en and at the boundary.
  - Instantiated three times in a chain (cs -> secs -> mins).
- Divider and FSM stay in the top level.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), MIN_MAX=59.
- Up count: reset, start_stop, run 600 clocks -> cs=60, secs=0, running=1. Run to 100 ticks -> cs=0, secs=1.
- Rollover: load 59:59:98, start up, 20 clocks -> counters 00:00:00, wrap high exactly 1 cycle.
- Countdown: mode_down=1, load 00:01:05, start -> reaches 00:00:00 after 105 ticks (1050 clocks); done 1 cycle; expired=1; counters hold 0. A further start_stop -> IDLE, expired=0.
- Lap: up run 300 clocks, lap -> disp=00:00:30 frozen while cs advances to 50. Second lap -> disp tracks live.
- Pause/clear:
  - start, 55 clocks, start_stop -> cs=5, divider held; resume, 5 clocks -> cs=6.
  - start_stop, then lap in PAUSE -> all zero, IDLE.
  - start_stop+lap in the same cycle in RUN -> PAUSE, lap_hold unchanged.
- Guards:
  - load in RUN ignored.
  - Preset secs=63 -> secs=59.
  - Down mode start with zero counters -> stays IDLE.
  - Reset asserted mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch/countdown time base.
//   state_e : top-level control states
//   CS_*    : centisecond field range and width
//   SEC_*   : seconds field range and width
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned CS_MAX  = 99;
   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned CS_W    = 7;
   localparam int unsigned SEC_W   = 6;

endpackage

// File: rtl/stopwatch_timer_if.sv
// Control and display bundle between the debounce/preset logic and the time base.
//   Controls : start_stop, lap, load (1-cycle pulses), mode_down, preset_cs/secs/mins
//   Status   : cs/secs/mins (live), disp_* (live or lap), running, lap_hold,
//              done (pulse), expired (level), wrap (pulse)
//   master   : drives controls, observes status
//   slave    : the time base itself
interface stopwatch_timer_if
   import stopwatch_pkg::*;
#(
   parameter int unsigned MW = 6
);

   logic             start_stop;
   logic             lap;
   logic             mode_down;
   logic             load;
   logic [CS_W-1:0]  preset_cs;
   logic [SEC_W-1:0] preset_secs;
   logic [MW-1:0]    preset_mins;

   logic [CS_W-1:0]  cs;
   logic [SEC_W-1:0] secs;
   logic [MW-1:0]    mins;
   logic [CS_W-1:0]  disp_cs;
   logic [SEC_W-1:0] disp_secs;
   logic [MW-1:0]    disp_mins;
   logic             running;
   logic             lap_hold;
   logic             done;
   logic             expired;
   logic             wrap;

   modport master (
      output start_stop, lap, mode_down, load, preset_cs, preset_secs, preset_mins,
      input  cs, secs, mins, disp_cs, disp_secs, disp_mins,
      input  running, lap_hold, done, expired, wrap
   );

   modport slave (
      input  start_stop, lap, mode_down, load, preset_cs, preset_secs, preset_mins,
      output cs, secs, mins, disp_cs, disp_secs, disp_mins,
      output running, lap_hold, done, expired, wrap
   );

endinterface

// File: rtl/wrap_updown_counter.sv
// Modulo-(MAX+1) up/down counter stage for chaining time fields.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance one step
//   down       : 1 = decrement, 0 = increment
//   load       : load load_val (takes priority over en)
//   cnt        : registered count
//   co_c       : combinational carry (up, at MAX) / borrow (down, at 0) while en
module wrap_updown_counter #(
   parameter int unsigned MAX   = 99,
   parameter int unsigned WIDTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             co_c
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Next count: load beats stepping; wrap at either end of the range.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en) begin
         if (down) begin
            cnt_d = (cnt_q == '0) ? WIDTH'(MAX) : cnt_q - WIDTH'(1);
         end else begin
            cnt_d = (cnt_q == WIDTH'(MAX)) ? '0 : cnt_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign co_c = en && (down ? (cnt_q == '0) : (cnt_q == WIDTH'(MAX)));
   assign cnt  = cnt_q;

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch (up) / countdown timer (down) time base with lap hold and preset load.
//   clk, reset : clock, synchronous active-high reset
//   sw         : stopwatch_timer_if slave port (controls in, counters/status out)
// The tick divider and control FSM live here; the three time fields are a
// carry/borrow chain of wrap_updown_counter stages (cs -> secs -> mins).
module stopwatch_timer
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 100,
   parameter int unsigned MIN_MAX = 59,
   parameter int unsigned MW      = $clog2(MIN_MAX + 1)
) (
   input logic              clk,
   input logic              reset,
   stopwatch_timer_if.slave sw
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             mode_q, mode_d;       // latched direction, 1 = down
   logic             lap_hold_q, lap_hold_d;
   logic             done_q, done_d;
   logic             wrap_q, wrap_d;
   logic [CS_W-1:0]  lap_cs_q, lap_cs_d;
   logic [SEC_W-1:0] lap_secs_q, lap_secs_d;
   logic [MW-1:0]    lap_mins_q, lap_mins_d;

   logic [CS_W-1:0]  cs_cnt;
   logic [SEC_W-1:0] secs_cnt;
   logic [MW-1:0]    mins_cnt;
   logic             cs_co, secs_co, mins_co;

   logic             tick_c;
   logic             cnt_load_c;
   logic             cnt_clr_c;
   logic             all_zero_c;
   logic             at_one_c;
   logic             start_down_c;
   logic [CS_W-1:0]  pre_cs_c;
   logic [SEC_W-1:0] pre_secs_c;
   logic [MW-1:0]    pre_mins_c;

   assign tick_c     = (state_q == RUN) && (div_q == DIV_W'(DIV - 1));
   assign all_zero_c = (cs_cnt == '0) && (secs_cnt == '0) && (mins_cnt == '0);
   // One step from zero while counting down: the next tick expires the timer.
   assign at_one_c   = (cs_cnt == CS_W'(1)) && (secs_cnt == '0) && (mins_cnt == '0);

   // Direction that a start would use: live input from IDLE, latched from PAUSE.
   assign start_down_c = (state_q == IDLE) ? sw.mode_down : mode_q;

   // Preset saturation to each field's legal range.
   assign pre_cs_c   = (sw.preset_cs   > CS_W'(CS_MAX))   ? CS_W'(CS_MAX)   : sw.preset_cs;
   assign pre_secs_c = (sw.preset_secs > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : sw.preset_secs;
   assign pre_mins_c = (sw.preset_mins > MW'(MIN_MAX))    ? MW'(MIN_MAX)    : sw.preset_mins;

   wrap_updown_counter #(.MAX(CS_MAX), .WIDTH(CS_W)) u_cs (
      .clk      (clk),
      .reset    (reset),
      .en       (tick_c),
      .down     (mode_q),
      .load     (cnt_load_c),
      .load_val (cnt_clr_c ? '0 : pre_cs_c),
      .cnt      (cs_cnt),
      .co_c     (cs_co)
   );

   wrap_updown_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_secs (
      .clk      (clk),
      .reset    (reset),
      .en       (cs_co),
      .down     (mode_q),
      .load     (cnt_load_c),
      .load_val (cnt_clr_c ? '0 : pre_secs_c),
      .cnt      (secs_cnt),
      .co_c     (secs_co)
   );

   wrap_updown_counter #(.MAX(MIN_MAX), .WIDTH(MW)) u_mins (
      .clk      (clk),
      .reset    (reset),
      .en       (secs_co),
      .down     (mode_q),
      .load     (cnt_load_c),
      .load_val (cnt_clr_c ? '0 : pre_mins_c),
      .cnt      (mins_cnt),
      .co_c     (mins_co)
   );

   // Control FSM: next state, divider, lap capture and counter load/clear.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      mode_d     = mode_q;
      lap_hold_d = lap_hold_q;
      lap_cs_d   = lap_cs_q;
      lap_secs_d = lap_secs_q;
      lap_mins_d = lap_mins_q;
      done_d     = 1'b0;
      wrap_d     = 1'b0;
      cnt_load_c = 1'b0;
      cnt_clr_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (sw.start_stop) begin
               if (!(start_down_c && all_zero_c)) begin
                  state_d = RUN;
                  mode_d  = sw.mode_down;
                  div_d   = '0;
               end
            end else if (sw.load) begin
               cnt_load_c = 1'b1;
               lap_hold_d = 1'b0;
               div_d      = '0;
            end else if (sw.lap) begin
               lap_hold_d = 1'b0;
            end
         end

         RUN: begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
            // Lap captures the pre-tick value; start_stop in the same cycle wins.
            if (sw.lap && !sw.start_stop) begin
               if (!lap_hold_q) begin
                  lap_cs_d   = cs_cnt;
                  lap_secs_d = secs_cnt;
                  lap_mins_d = mins_cnt;
                  lap_hold_d = 1'b1;
               end else begin
                  lap_hold_d = 1'b0;
               end
            end
            if (!mode_q && mins_co) begin
               wrap_d = 1'b1;
            end
            if (tick_c && mode_q && at_one_c) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else if (sw.start_stop) begin
               state_d = PAUSE;
            end
         end

         PAUSE: begin
            if (sw.start_stop) begin
               if (!(start_down_c && all_zero_c)) begin
                  state_d = RUN;
               end
            end else if (sw.lap) begin
               cnt_load_c = 1'b1;
               cnt_clr_c  = 1'b1;
               lap_cs_d   = '0;
               lap_secs_d = '0;
               lap_mins_d = '0;
               lap_hold_d = 1'b0;
               div_d      = '0;
               state_d    = IDLE;
            end else if (sw.load) begin
               cnt_load_c = 1'b1;
               lap_hold_d = 1'b0;
               div_d      = '0;
            end
         end

         DONE: begin
            if (sw.start_stop || sw.load) begin
               state_d = IDLE;
            end
            if (sw.load) begin
               cnt_load_c = 1'b1;
               lap_hold_d = 1'b0;
               div_d      = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         div_q      <= '0;
         mode_q     <= 1'b0;
         lap_hold_q <= 1'b0;
         done_q     <= 1'b0;
         wrap_q     <= 1'b0;
         lap_cs_q   <= '0;
         lap_secs_q <= '0;
         lap_mins_q <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         mode_q     <= mode_d;
         lap_hold_q <= lap_hold_d;
         done_q     <= done_d;
         wrap_q     <= wrap_d;
         lap_cs_q   <= lap_cs_d;
         lap_secs_q <= lap_secs_d;
         lap_mins_q <= lap_mins_d;
      end
   end

   assign sw.cs        = cs_cnt;
   assign sw.secs      = secs_cnt;
   assign sw.mins      = mins_cnt;
   assign sw.disp_cs   = lap_hold_q ? lap_cs_q   : cs_cnt;
   assign sw.disp_secs = lap_hold_q ? lap_secs_q : secs_cnt;
   assign sw.disp_mins = lap_hold_q ? lap_mins_q : mins_cnt;
   assign sw.running   = (state_q == RUN);
   assign sw.expired   = (state_q == DONE);
   assign sw.lap_hold  = lap_hold_q;
   assign sw.done      = done_q;
   assign sw.wrap      = wrap_q;

endmodule
